fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Sequences instruction fetch for the RV32I pipeline. Owns the PC, issues
//   single-outstanding imem requests, and arbitrates PC redirects (branch,
//   jump/jalr, fusion skip), load-use stalls and IF/ID flushes. It sits
//   between the hazard/branch logic and the instruction memory, feeding IF/ID.
// PARAMETERS
//   RESET_VECTOR   32'h0000_0000  PC value after reset
//   FLUSH_BUBBLES  2              cycles flush stays high per redirect (1..7)
//   STALL_TIMEOUT  255            consecutive stall cycles before timeout_err; 0 disables
// PORTS
//   clk            in   1   clock, all state on posedge
//   rst            in   1   synchronous, active-high reset
//   imem_req       out  1   fetch request valid
//   imem_addr      out  32  fetch address (always == pc_out while imem_req)
//   imem_gnt       in   1   request accepted this cycle
//   imem_rvalid    in   1   response data valid
//   imem_rdata     in   32  response instruction
//   branch_taken   in   1   resolved taken branch (1-cycle pulse)
//   branch_target  in   32  branch target
//   jump_valid     in   1   jal/jalr redirect (1-cycle pulse)
//   jump_target    in   32  jump target
//   fuse_skip      in   1   next sequential step is +8 (fused pair decoded)
//   load_pending   in   1   load in MEM awaiting data
//   dmem_valid     in   1   load data returned
//   pc_out         out  32  next fetch address
//   if_pc          out  32  address of instruction on if_instr
//   if_instr       out  32  fetched instruction to IF/ID
//   if_valid       out  1   if_instr/if_pc valid (1-cycle per instruction)
//   flush          out  1   kill IF/ID contents
//   stall          out  1   pipeline hold (= load_pending & !dmem_valid)
//   timeout_err    out  1   sticky stall-timeout flag
// BEHAVIOUR
//   Reset: pc_out=if_pc=RESET_VECTOR, if_instr=0, imem_req=if_valid=flush=0,
//     timeout_err=0, kill=0, hold buffer empty, state IDLE. IDLE->FETCH next cycle.
//   States: IDLE, FETCH, WAIT_RSP, DRAIN.
//   FETCH: imem_req=1 unless stall; imem_gnt -> WAIT_RSP. imem_gnt ignored when req=0.
//   WAIT_RSP: imem_req=0. On imem_rvalid: capture rdata/pc, pc_out<=pc+4 (pc+8 if
//     skip latched), -> FETCH. if_valid asserts the cycle after rvalid.
//   fuse_skip: latched on pulse, consumed (cleared) at the next sequential advance.
//   Redirect priority: branch_taken > jump_valid > sequential. Redirect cycle N:
//     pc_out<=target&~3 at N+1; skip latch cleared; flush high N+1..N+FLUSH_BUBBLES;
//     if_valid forced 0 while flush. If in WAIT_RSP (or gnt same cycle) -> DRAIN:
//     wait rvalid, discard it, -> FETCH. Redirect in DRAIN: update pc only.
//   Stall: pc_out and if_pc held; no new request issued; rvalid during stall
//     goes into 1-entry hold buffer, if_valid presented the cycle after stall
//     drops. Redirect during stall still updates pc_out and clears hold buffer.
//   timeout_err: counter increments each stall cycle, clears when stall=0;
//     sets timeout_err when count == STALL_TIMEOUT; sticky until rst.
//   Arithmetic: PC adds modulo 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000).
//   rst mid-transaction: outstanding response discarded; state returns to IDLE.
// TESTING
//   Reset, gnt=1, rvalid 1 cycle after gnt -> if_pc 0x0,0x4,0x8; if_valid per instr.
//   branch_taken=1 target 0x100 while in WAIT_RSP -> DRAIN, pending rsp dropped,
//     flush high 2 cycles, next imem_addr=0x100.
//   branch_taken and jump_valid same cycle (0x200 / 0x300) -> pc_out=0x200.
//   fuse_skip pulse at pc 0x40 -> next fetch 0x48, then 0x4C.
//   load_pending=1,dmem_valid=0 for 10 cycles with rvalid in stall -> no req,
//     pc held, instr held, if_valid 1 cycle after release; STALL_TIMEOUT=8 -> timeout_err=1.
//   RESET_VECTOR=0xFFFF_FFFC -> second fetch at 0x0000_0000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding imem
// request at a time, arbitrates redirects, stalls and IF/ID flushes.
`timescale 1ns/1ps

module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter int unsigned FLUSH_BUBBLES = 2,
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        fuse_skip,
    input  logic        load_pending,
    input  logic        dmem_valid,
    output logic [31:0] pc_out,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        flush,
    output logic        stall,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STALL_TIMEOUT);
    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_BUBBLES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_if_pc;
    logic [31:0]        r_if_instr;
    logic               r_if_valid;
    logic               r_flush;
    logic [2:0]         r_flush_cnt;
    logic               r_skip;
    logic               r_hold_valid;
    logic [31:0]        r_hold_instr;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_timeout;

    logic               w_stall;
    logic               w_req;
    logic               w_gnt;
    logic               w_redirect;
    logic [31:0]        w_target;
    logic [31:0]        w_target_al;
    logic               w_use_skip;
    logic [31:0]        w_pc_seq;
    logic               w_release;
    logic               w_capture;
    logic               w_advance;
    logic               w_flush_load;
    logic               w_flush_nxt;

    // Hazard, redirect and sequential-step decode
    assign w_stall      = load_pending & ~dmem_valid;
    assign w_req        = (r_state == ST_FETCH) & ~w_stall & ~r_hold_valid;
    assign w_gnt        = w_req & imem_gnt;
    assign w_redirect   = branch_taken | jump_valid;
    assign w_target     = branch_taken ? branch_target : jump_target;
    assign w_target_al  = {w_target[31:2], 2'b00};
    assign w_use_skip   = r_skip | fuse_skip;
    assign w_pc_seq     = r_pc + (w_use_skip ? 32'd8 : 32'd4);
    assign w_release    = (r_state == ST_FETCH) & r_hold_valid & ~w_stall;
    assign w_capture    = (r_state == ST_WAIT_RSP) & imem_rvalid & ~w_stall;
    assign w_advance    = ~w_redirect & (w_release | w_capture);
    assign w_flush_load = w_redirect & (r_state != ST_DRAIN);
    assign w_flush_nxt  = w_flush_load | (r_flush_cnt > 3'd1);

    // Request is decoded from the state register and the live hazard so it drops in the stall cycle itself
    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign if_pc       = r_if_pc;
    assign if_instr    = r_if_instr;
    assign if_valid    = r_if_valid;
    assign flush       = r_flush;
    assign stall       = w_stall;
    assign timeout_err = r_timeout;

    // Flush bubble counter, fused-pair skip latch and stall watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= 3'd0;
            r_flush     <= 1'b0;
            r_skip      <= 1'b0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_flush_load) begin
                r_flush_cnt <= FLUSH_INIT;
            end else if (r_flush_cnt != 3'd0) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
            r_flush <= w_flush_nxt;

            if (w_redirect || w_advance) begin
                r_skip <= 1'b0;
            end else if (fuse_skip) begin
                r_skip <= 1'b1;
            end

            if (!w_stall) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if ((STALL_TIMEOUT != 0) && (r_stall_cnt == CNT_MAX)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Fetch FSM: PC, IF/ID outputs and stall hold buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_VECTOR;
            r_if_pc      <= RESET_VECTOR;
            r_if_instr   <= 32'd0;
            r_if_valid   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_instr <= 32'd0;
        end else begin
            r_if_valid <= w_advance & ~w_flush_nxt;
            if (w_redirect) begin
                // A response still owed for the old path must be swallowed in DRAIN
                r_pc         <= w_target_al;
                r_hold_valid <= 1'b0;
                case (r_state)
                    ST_IDLE:     r_state <= ST_FETCH;
                    ST_FETCH:    r_state <= w_gnt ? ST_DRAIN : ST_FETCH;
                    ST_WAIT_RSP: r_state <= imem_rvalid ? ST_FETCH : ST_DRAIN;
                    ST_DRAIN:    r_state <= imem_rvalid ? ST_FETCH : ST_DRAIN;
                    default:     r_state <= ST_IDLE;
                endcase
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_FETCH;
                    ST_FETCH: begin
                        if (w_release) begin
                            r_pc         <= w_pc_seq;
                            r_if_pc      <= r_pc;
                            r_if_instr   <= r_hold_instr;
                            r_hold_valid <= 1'b0;
                        end else if (w_gnt) begin
                            r_state <= ST_WAIT_RSP;
                        end
                    end
                    ST_WAIT_RSP: begin
                        if (imem_rvalid) begin
                            r_state <= ST_FETCH;
                            if (w_stall) begin
                                r_hold_valid <= 1'b1;
                                r_hold_instr <= imem_rdata;
                            end else begin
                                r_pc       <= w_pc_seq;
                                r_if_pc    <= r_pc;
                                r_if_instr <= imem_rdata;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (imem_rvalid) begin
                            r_state <= ST_FETCH;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: imem responder, if_valid scoreboard, redirect vector table.
`timescale 1ns/1ps

module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        fuse_skip;
    logic        load_pending;
    logic        dmem_valid;

    logic        imem_req, if_valid, flush, stall, timeout_err;
    logic [31:0] imem_addr, pc_out, if_pc, if_instr;
    logic        d2_imem_req, d2_if_valid, d2_flush, d2_stall, d2_timeout_err;
    logic [31:0] d2_imem_addr, d2_pc_out, d2_if_pc, d2_if_instr;

    fetch_ctrl #(.RESET_VECTOR(32'h0000_0000), .FLUSH_BUBBLES(2), .STALL_TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_valid(jump_valid), .jump_target(jump_target), .fuse_skip(fuse_skip),
        .load_pending(load_pending), .dmem_valid(dmem_valid), .pc_out(pc_out),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .flush(flush),
        .stall(stall), .timeout_err(timeout_err)
    );

    fetch_ctrl #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst), .imem_req(d2_imem_req), .imem_addr(d2_imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_valid(jump_valid), .jump_target(jump_target), .fuse_skip(fuse_skip),
        .load_pending(load_pending), .dmem_valid(dmem_valid), .pc_out(d2_pc_out),
        .if_pc(d2_if_pc), .if_instr(d2_if_instr), .if_valid(d2_if_valid), .flush(d2_flush),
        .stall(d2_stall), .timeout_err(d2_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb_q[$];
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          lat;
    int          d2_n;
    logic [31:0] d2_pc[2];

    typedef struct {
        logic        br;
        logic [31:0] bt;
        logic        jv;
        logic [31:0] jt;
        logic [31:0] exp_pc;
        logic        exp_flush;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // One clock: memory responder before the edge, if_valid scoreboard after it
    task automatic cycle();
        logic [31:0] e;
        #1;
        imem_rvalid = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(pend_addr);
                pend        = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_addr = imem_addr;
        end
        @(posedge clk);
        #2;
        if (if_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_if_valid: if_pc 0x%08h while nothing expected", if_pc);
            end else begin
                e = sb_q.pop_front();
                check32("sb_if_pc", if_pc, e);
                check32("sb_if_instr", if_instr, instr_of(e));
            end
        end
        if (d2_if_valid === 1'b1 && d2_n < 2) begin
            d2_pc[d2_n] = d2_if_pc;
            d2_n++;
        end
    endtask

    // Run until every expected fetch has been seen, then stop granting
    task automatic run_drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) cycle();
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL sb_timeout: %0d fetches still outstanding after %0d cycles", sb_q.size(), budget);
        imem_gnt = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int req_bad;
        int pc_bad;

        vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0000_0100, 1'b1};
        vecs[1] = '{1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 32'h0000_0200, 1'b1};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h0000_0300, 32'h0000_0300, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_1003, 1'b0, 32'h0,         32'h0000_1000, 1'b1};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 32'h0000_02FF, 32'h0000_02FC, 1'b1};
        vecs[5] = '{1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0000_0010, 32'hFFFF_FFFC, 1'b1};
        vecs[6] = '{1'b0, 32'h0,         1'b0, 32'h0,         32'hFFFF_FFFC, 1'b0};
        vecs[7] = '{1'b0, 32'h0,         1'b1, 32'h0000_0041, 32'h0000_0040, 1'b1};

        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        branch_taken = 1'b0; branch_target = 32'h0; jump_valid = 1'b0; jump_target = 32'h0;
        fuse_skip = 1'b0; load_pending = 1'b0; dmem_valid = 1'b0;
        pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0; lat = 0; d2_n = 0;

        // Reset state
        cycle(); cycle();
        check1 ("rst_imem_req", imem_req, 1'b0);
        check32("rst_pc_out", pc_out, 32'h0);
        check32("rst_if_pc", if_pc, 32'h0);
        check32("rst_if_instr", if_instr, 32'h0);
        check1 ("rst_if_valid", if_valid, 1'b0);
        check1 ("rst_flush", flush, 1'b0);
        check1 ("rst_timeout_err", timeout_err, 1'b0);
        check32("rst_wrap_pc_out", d2_pc_out, 32'hFFFF_FFFC);
        check32("rst_wrap_imem_addr", d2_imem_addr, 32'hFFFF_FFFC);
        check32("rst_wrap_if_pc", d2_if_pc, 32'hFFFF_FFFC);
        check32("rst_wrap_if_instr", d2_if_instr, 32'h0);
        check1 ("rst_wrap_req", d2_imem_req, 1'b0);
        check1 ("rst_wrap_if_valid", d2_if_valid, 1'b0);
        check1 ("rst_wrap_flush", d2_flush, 1'b0);
        check1 ("rst_wrap_timeout", d2_timeout_err, 1'b0);

        // Sequential fetch from reset, response one cycle after grant
        rst = 1'b0; imem_gnt = 1'b1;
        sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8);
        run_drain(40);
        check32("seq_pc_out", pc_out, 32'hC);
        check32("wrap_count", 32'(d2_n), 32'd2);
        check32("wrap_first_pc", d2_pc[0], 32'hFFFF_FFFC);
        check32("wrap_second_pc", d2_pc[1], 32'h0000_0000);

        // Redirect priority and alignment table, applied while idle in FETCH
        for (int v = 0; v < 8; v++) begin
            branch_taken = vecs[v].br; branch_target = vecs[v].bt;
            jump_valid   = vecs[v].jv; jump_target   = vecs[v].jt;
            cycle();
            branch_taken = 1'b0; jump_valid = 1'b0;
            check32($sformatf("vec%0d_pc_out", v), pc_out, vecs[v].exp_pc);
            check32($sformatf("vec%0d_imem_addr", v), imem_addr, vecs[v].exp_pc);
            check1 ($sformatf("vec%0d_flush1", v), flush, vecs[v].exp_flush);
            cycle();
            check1 ($sformatf("vec%0d_flush2", v), flush, vecs[v].exp_flush);
            cycle();
            check1 ($sformatf("vec%0d_flush3", v), flush, 1'b0);
        end

        // Fused pair at 0x40: one +8 step, then back to +4
        fuse_skip = 1'b1;
        cycle();
        fuse_skip = 1'b0;
        check32("fuse_pc_held", pc_out, 32'h40);
        imem_gnt = 1'b1;
        sb_q.push_back(32'h40); sb_q.push_back(32'h48); sb_q.push_back(32'h4C);
        run_drain(40);
        check32("fuse_pc_after", pc_out, 32'h50);

        // Branch while waiting for a response: drain it, two flush cycles, refetch at target
        lat = 2; imem_gnt = 1'b1;
        cycle();
        branch_taken = 1'b1; branch_target = 32'h100;
        cycle();
        branch_taken = 1'b0; lat = 0;
        check32("drain_pc_out", pc_out, 32'h100);
        check1 ("drain_flush1", flush, 1'b1);
        check1 ("drain_req_off1", imem_req, 1'b0);
        sb_q.push_back(32'h100); sb_q.push_back(32'h104);
        cycle();
        check1 ("drain_flush2", flush, 1'b1);
        check1 ("drain_req_off2", imem_req, 1'b0);
        cycle();
        check1 ("drain_flush_end", flush, 1'b0);
        check1 ("drain_req_on", imem_req, 1'b1);
        check32("drain_imem_addr", imem_addr, 32'h100);
        run_drain(40);
        check32("drain_pc_after", pc_out, 32'h108);

        // Load-use stall for 10 cycles with the response landing mid-stall
        imem_gnt = 1'b1;
        cycle();
        imem_gnt = 1'b0;
        check1("pre_stall_timeout", timeout_err, 1'b0);
        load_pending = 1'b1; dmem_valid = 1'b1;
        #1;
        check1("stall_data_back", stall, 1'b0);
        dmem_valid = 1'b0;
        #1;
        check1("stall_active", stall, 1'b1);
        check1("wrap_stall_active", d2_stall, 1'b1);
        req_bad = 0; pc_bad = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (imem_req !== 1'b0) req_bad++;
            if (pc_out !== 32'h108) pc_bad++;
        end
        check32("stall_no_req", 32'(req_bad), 32'd0);
        check32("stall_pc_held", 32'(pc_bad), 32'd0);
        check32("stall_if_pc_held", if_pc, 32'h104);
        check32("stall_instr_held", if_instr, instr_of(32'h104));
        check1 ("stall_timeout_set", timeout_err, 1'b1);
        check1 ("wrap_no_timeout", d2_timeout_err, 1'b0);
        load_pending = 1'b0;
        sb_q.push_back(32'h108);
        cycle();
        check1 ("release_if_valid", if_valid, 1'b1);
        check32("release_pc_out", pc_out, 32'h10C);
        cycle();
        check1 ("timeout_sticky", timeout_err, 1'b1);
        check1 ("release_valid_pulse", if_valid, 1'b0);

        // Reset with a response outstanding: the late response must be ignored
        lat = 3; imem_gnt = 1'b1;
        cycle();
        imem_gnt = 1'b0; rst = 1'b1;
        cycle();
        check32("midrst_pc_out", pc_out, 32'h0);
        check1 ("midrst_req", imem_req, 1'b0);
        check1 ("midrst_timeout_clr", timeout_err, 1'b0);
        check1 ("midrst_if_valid", if_valid, 1'b0);
        check32("midrst_wrap_pc", d2_pc_out, 32'hFFFF_FFFC);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check32("midrst_pc_idle", pc_out, 32'h0);
        lat = 0; imem_gnt = 1'b1;
        sb_q.push_back(32'h0); sb_q.push_back(32'h4);
        run_drain(40);
        check32("midrst_pc_after", pc_out, 32'h8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
